// File: rtl/fifo_thresh.sv
// fifo_thresh: single-clock FIFO with programmable almost-full/almost-empty
// thresholds. Full/empty come from an occupancy counter rather than a
// pointer comparison. The read port is registered with one cycle of latency.
//
// Optional build macro FIFO_STICKY_ERR_EN:
//   defined   -> overflow/underflow latch high until reset
//   undefined -> overflow/underflow pulse for one cycle after the bad request
module fifo_thresh #(
    parameter int DATA_WIDTH       = 10,
    parameter int ADDR_WIDTH       = 3,
    parameter int ALMOST_FULL_LVL  = 6,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] OCC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic is_empty;
    logic is_full;
    logic do_push;
    logic do_pop;
    logic ovf_event;
    logic unf_event;

    // Acceptance decisions use only registered occupancy, so a pop never
    // reads through a same-cycle push into an empty FIFO. A full FIFO may
    // still take a push when a pop frees a slot in the same cycle.
    assign is_empty  = (occupancy == '0);
    assign is_full   = (occupancy == OCC_FULL);
    assign do_pop    = pop && !is_empty;
    assign do_push   = push && (!is_full || do_pop);
    assign ovf_event = push && !do_push;
    assign unf_event = pop && is_empty;

    // Status flags are pure decodes of the occupancy register.
    assign fifo_empty   = is_empty;
    assign fifo_full    = is_full;
    assign almost_full  = (int'(occupancy) >= ALMOST_FULL_LVL);
    assign almost_empty = (int'(occupancy) <= ALMOST_EMPTY_LVL);

    // Storage array: written on accepted pushes only and never cleared.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at the depth; occupancy tracks net push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Registered read port: data_out holds its value between accepted pops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= do_pop;
            if (do_pop) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    // Error reporting for rejected requests, either sticky or as pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            overflow  <= overflow  | ovf_event;
            underflow <= underflow | unf_event;
`else
            overflow  <= ovf_event;
            underflow <= unf_event;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: directed testbench for fifo_thresh. The stimulus pushes each
// expected read word into a queue whenever it issues a pop that should be
// accepted. A monitor compares data_out against that queue every time
// valid_out is high. The stimulus checks status flags directly.
module tb_fifo_thresh;

    localparam int DW = 10;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   occupancy;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q [$];

    logic [DW-1:0] drain4 [8] = '{10'h002, 10'h003, 10'h004, 10'h005,
                                  10'h006, 10'h007, 10'h008, 10'h155};

`ifdef FIFO_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    fifo_thresh #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .ALMOST_FULL_LVL  (6),
        .ALMOST_EMPTY_LVL (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .occupancy    (occupancy),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and record the result.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of requests at the falling edge, then return just after
    // the rising edge with the requests dropped.
    task automatic apply_stimulus(input logic p, input logic [DW-1:0] d, input logic q);
        @(negedge clk);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Hold reset low for n cycles while also requesting push and pop.
    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset   = 1'b0;
            push    = 1'b1;
            pop     = 1'b1;
            data_in = 10'h3FF;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    // Monitor: each valid_out cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_valid: data_out=%0h, expected no output", data_out);
            end else begin
                check_output("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        reset   = 1'b0;
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 10'h3FF;

        // Reset with both requests active.
        apply_reset(2);
        check_output("rst_occupancy", 32'(occupancy), 0);
        check_output("rst_empty", 32'(fifo_empty), 1);
        check_output("rst_almost_empty", 32'(almost_empty), 1);
        check_output("rst_full", 32'(fifo_full), 0);
        check_output("rst_almost_full", 32'(almost_full), 0);
        check_output("rst_data_out", 32'(data_out), 0);
        check_output("rst_valid_out", 32'(valid_out), 0);
        check_output("rst_overflow", 32'(overflow), 0);
        check_output("rst_underflow", 32'(underflow), 0);

        // Fill to full, watching the threshold flags.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 10'(i), 1'b0);
            check_output("fill_occupancy", 32'(occupancy), 32'(i));
            check_output("fill_almost_empty", 32'(almost_empty), (i <= 2) ? 1 : 0);
            check_output("fill_almost_full", 32'(almost_full), (i >= 6) ? 1 : 0);
            check_output("fill_full", 32'(fifo_full), (i == 8) ? 1 : 0);
        end
        apply_stimulus(1'b1, 10'h3FF, 1'b0);
        check_output("ovf_flag", 32'(overflow), 1);
        check_output("ovf_occupancy", 32'(occupancy), 8);
        apply_stimulus(1'b0, 10'h000, 1'b0);
        check_output("ovf_after", 32'(overflow), 32'(STICKY));

        // Drain in order, then underflow.
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(10'(i));
            apply_stimulus(1'b0, 10'h000, 1'b1);
            check_output("drain_valid", 32'(valid_out), 1);
            check_output("drain_occupancy", 32'(occupancy), 32'(8 - i));
        end
        check_output("drain_empty", 32'(fifo_empty), 1);
        apply_stimulus(1'b0, 10'h000, 1'b1);
        check_output("unf_flag", 32'(underflow), 1);
        check_output("unf_valid", 32'(valid_out), 0);
        check_output("unf_data_hold", 32'(data_out), 32'h008);

        // Simultaneous push and pop while full.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 10'(i), 1'b0);
        end
        check_output("refill_full", 32'(fifo_full), 1);
        exp_q.push_back(10'h001);
        apply_stimulus(1'b1, 10'h155, 1'b1);
        check_output("pp_full_occupancy", 32'(occupancy), 8);
        check_output("pp_full_overflow", 32'(overflow), 0);
        check_output("pp_full_valid", 32'(valid_out), 1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(drain4[i]);
            apply_stimulus(1'b0, 10'h000, 1'b1);
        end
        check_output("pp_full_drained", 32'(occupancy), 0);

        // Simultaneous push and pop while empty: no read-through.
        apply_stimulus(1'b1, 10'h0AA, 1'b1);
        check_output("pp_empty_occupancy", 32'(occupancy), 1);
        check_output("pp_empty_valid", 32'(valid_out), 0);
        check_output("pp_empty_underflow", 32'(underflow), 1);
        exp_q.push_back(10'h0AA);
        apply_stimulus(1'b0, 10'h000, 1'b1);
        check_output("pp_empty_after_occ", 32'(occupancy), 0);

        // Interleaved traffic across pointer wrap, then reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 10'(16 + k), 1'b0);
        end
        for (int k = 3; k < 20; k++) begin
            exp_q.push_back(10'(16 + k - 3));
            apply_stimulus(1'b1, 10'(16 + k), 1'b1);
            check_output("wrap_occupancy", 32'(occupancy), 3);
        end
        apply_reset(1);
        @(posedge clk);
        #1;
        check_output("midrst_occupancy", 32'(occupancy), 0);
        check_output("midrst_empty", 32'(fifo_empty), 1);
        check_output("midrst_valid", 32'(valid_out), 0);
        apply_stimulus(1'b1, 10'h2A5, 1'b0);
        check_output("post_rst_occupancy", 32'(occupancy), 1);
        exp_q.push_back(10'h2A5);
        apply_stimulus(1'b0, 10'h000, 1'b1);
        apply_stimulus(1'b0, 10'h000, 1'b0);
        check_output("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
